// File: rtl/timer_pwm_pkg.sv
// rtl/timer_pwm_pkg.sv - register map constants and index enum for timer_pwm
package timer_pwm_pkg;

  localparam logic [3:0] PCR_OFFSET = 4'h0;
  localparam logic [3:0] CCR_OFFSET = 4'h4;
  localparam logic [3:0] SR_OFFSET  = 4'h8;
  localparam logic [3:0] DTR_OFFSET = 4'hC;

  localparam int PCR_EN_BIT   = 0;
  localparam int PCR_POL_BIT  = 1;
  localparam int PCR_CCIE_BIT = 2;
  localparam int PCR_UIE_BIT  = 3;

  localparam int SR_CCIF_BIT = 0;
  localparam int SR_UIF_BIT  = 1;

  typedef enum logic [1:0] {
    REG_PCR = 2'd0,
    REG_CCR = 2'd1,
    REG_SR  = 2'd2,
    REG_DTR = 2'd3
  } reg_idx_e;

  // Registers are word spaced, so only the upper two address bits select one.
  function automatic reg_idx_e reg_idx(input logic [1:0] word_addr);
    return reg_idx_e'(word_addr);
  endfunction

endpackage

// File: rtl/timer_pwm_deadtime.sv
// rtl/timer_pwm_deadtime.sv - complementary output pair with programmable rising-edge dead time
module timer_pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ref_i,
  input  logic [DT_W-1:0] dtr_i,
  output logic            pwm_o,
  output logic            pwm_n_o
);

  logic            ref_q, ref_d;
  logic            pwm_q, pwm_d;
  logic            pwm_n_q, pwm_n_d;
  logic [DT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q   <= 1'b0;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ref_q   <= ref_d;
      pwm_q   <= pwm_d;
      pwm_n_q <= pwm_n_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any reference transition (re)starts the gap; outputs resume once it expires.
  always_comb begin
    ref_d   = ref_i;
    cnt_d   = cnt_q;
    pwm_d   = pwm_q;
    pwm_n_d = pwm_n_q;
    if (ref_i != ref_q) begin
      if (dtr_i == '0) begin
        cnt_d   = '0;
        pwm_d   = ref_i;
        pwm_n_d = !ref_i;
      end else begin
        cnt_d   = dtr_i;
        pwm_d   = 1'b0;
        pwm_n_d = 1'b0;
      end
    end else if (cnt_q > DT_W'(1)) begin
      cnt_d = cnt_q - DT_W'(1);
    end else begin
      cnt_d   = '0;
      pwm_d   = ref_q;
      pwm_n_d = !ref_q;
    end
  end

  assign pwm_o   = pwm_q;
  assign pwm_n_o = pwm_n_q;

endmodule

// File: rtl/timer_pwm.sv
// rtl/timer_pwm.sv - APB compare/PWM block with flags and IRQ; optional dead time via TIMER_PWM_DEADTIME_EN
module timer_pwm
  import timer_pwm_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic [31:0] cnt_i,
  output logic        pwm_o,
`ifdef TIMER_PWM_DEADTIME_EN
  output logic        pwm_n_o,
`endif
  output logic        irq_o
);

  logic            access, wr_en, rd_en, cnt_chg, ref_pwm;
  reg_idx_e        idx;
  logic [3:0]      pcr_q, pcr_d;
  logic [31:0]     ccr_q, ccr_d;
  logic [31:0]     cnt_d_q;
  logic [31:0]     prdata_q, prdata_d;
  logic            ccif_q, ccif_d, uif_q, uif_d;
  logic            pready_q, irq_q, irq_d;
  logic [DT_W-1:0] dtr_val;
  logic            unused_paddr;

  assign unused_paddr = ^PADDR[1:0];

  assign access  = PSEL && PENABLE;
  assign wr_en   = access && PWRITE;
  assign rd_en   = access && !PWRITE;
  assign idx     = reg_idx(PADDR[3:2]);
  assign cnt_chg = (cnt_i != cnt_d_q);

  assign ref_pwm = pcr_q[PCR_EN_BIT] ? ((cnt_i < ccr_q) ^ pcr_q[PCR_POL_BIT])
                                     : pcr_q[PCR_POL_BIT];

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      pcr_q    <= '0;
      ccr_q    <= '0;
      ccif_q   <= 1'b0;
      uif_q    <= 1'b0;
      cnt_d_q  <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      pcr_q    <= pcr_d;
      ccr_q    <= ccr_d;
      ccif_q   <= ccif_d;
      uif_q    <= uif_d;
      cnt_d_q  <= cnt_i;
      prdata_q <= prdata_d;
      pready_q <= access;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    pcr_d    = pcr_q;
    ccr_d    = ccr_q;
    prdata_d = prdata_q;
    if (wr_en && idx == REG_PCR) pcr_d = PWDATA[3:0];
    if (wr_en && idx == REG_CCR) ccr_d = PWDATA;
    if (rd_en) begin
      case (idx)
        REG_PCR: prdata_d = {28'd0, pcr_q};
        REG_CCR: prdata_d = ccr_q;
        REG_SR:  prdata_d = {30'd0, uif_q, ccif_q};
        default: prdata_d = 32'(dtr_val);
      endcase
    end
  end

  // A new event outranks a same-cycle write-1-to-clear.
  always_comb begin
    ccif_d = ccif_q;
    uif_d  = uif_q;
    if (wr_en && idx == REG_SR && PWDATA[SR_CCIF_BIT]) ccif_d = 1'b0;
    if (wr_en && idx == REG_SR && PWDATA[SR_UIF_BIT])  uif_d  = 1'b0;
    if (cnt_chg && cnt_i == ccr_q) ccif_d = 1'b1;
    if (cnt_chg && cnt_i == '0)    uif_d  = 1'b1;
    irq_d = (ccif_q && pcr_q[PCR_CCIE_BIT]) || (uif_q && pcr_q[PCR_UIE_BIT]);
  end

`ifdef TIMER_PWM_DEADTIME_EN
  logic [DT_W-1:0] dtr_q, dtr_d;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) dtr_q <= '0;
    else         dtr_q <= dtr_d;
  end

  always_comb begin
    dtr_d = dtr_q;
    if (wr_en && idx == REG_DTR) dtr_d = PWDATA[DT_W-1:0];
  end

  assign dtr_val = dtr_q;

  timer_pwm_deadtime #(.DT_W(DT_W)) u_deadtime (
    .clk_i   (PCLK),
    .rst_ni  (PRESET),
    .ref_i   (ref_pwm),
    .dtr_i   (dtr_q),
    .pwm_o   (pwm_o),
    .pwm_n_o (pwm_n_o)
  );
`else
  logic pwm_q;

  assign dtr_val = '0;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) pwm_q <= 1'b0;
    else         pwm_q <= ref_pwm;
  end

  assign pwm_o = pwm_q;
`endif

  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_timer_pwm.sv
// tb/tb_timer_pwm.sv - randomized and directed self-checking bench for timer_pwm (honours TIMER_PWM_DEADTIME_EN)
module tb_timer_pwm;

  localparam int BIG = 1 << 20;

  logic        PCLK    = 1'b0;
  logic        PRESET  = 1'b0;
  logic [3:0]  PADDR   = '0;
  logic [31:0] PWDATA  = '0;
  logic        PWRITE  = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL    = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [31:0] cnt_i   = '0;
  logic        pwm_o;
`ifdef TIMER_PWM_DEADTIME_EN
  logic        pwm_n_o;
`endif
  logic        irq_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 PCLK = ~PCLK;

  timer_pwm #(.DT_W(8)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .cnt_i   (cnt_i),
    .pwm_o   (pwm_o),
`ifdef TIMER_PWM_DEADTIME_EN
    .pwm_n_o (pwm_n_o),
`endif
    .irq_o   (irq_o)
  );

  // Reference: register map plus a run-length view of the PWM reference level.
  logic [3:0]  m_pcr = '0;
  logic [31:0] m_ccr = '0;
  logic [7:0]  m_dtr = '0;
  logic [31:0] m_prev = '0;
  logic [31:0] m_prdata = '0;
  bit          m_ccif = 0, m_uif = 0, m_pready = 0, m_irq = 0, m_live = 0;
  bit          run_val = 0;
  int          run_len = BIG;

  function automatic bit f_ref(input logic [3:0] pcr, input logic [31:0] ccr, input logic [31:0] c);
    if (!pcr[0]) return pcr[1];
    return (c < ccr) ? !pcr[1] : pcr[1];
  endfunction

  function automatic logic [31:0] f_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_pcr};
      2'd1:    return m_ccr;
      2'd2:    return {30'd0, m_uif, m_ccif};
      default: return {24'd0, m_dtr};
    endcase
  endfunction

  function automatic bit f_w1c(input int b);
    return PSEL && PENABLE && PWRITE && PADDR[3:2] == 2'd2 && PWDATA[b];
  endfunction

  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      m_pcr <= '0; m_ccr <= '0; m_dtr <= '0; m_prev <= '0; m_prdata <= '0;
      m_ccif <= 0; m_uif <= 0; m_pready <= 0; m_irq <= 0; m_live <= 0;
      run_val <= 0; run_len <= BIG;
    end else begin
      m_live   <= 1;
      m_prev   <= cnt_i;
      m_pready <= PSEL && PENABLE;
      if (PSEL && PENABLE && !PWRITE) m_prdata <= f_read(PADDR[3:2]);
      if (PSEL && PENABLE && PWRITE) begin
        if (PADDR[3:2] == 2'd0) m_pcr <= PWDATA[3:0];
        if (PADDR[3:2] == 2'd1) m_ccr <= PWDATA;
`ifdef TIMER_PWM_DEADTIME_EN
        if (PADDR[3:2] == 2'd3) m_dtr <= PWDATA[7:0];
`endif
      end
      m_ccif <= (cnt_i != m_prev && cnt_i == m_ccr) || (m_ccif && !f_w1c(0));
      m_uif  <= (cnt_i != m_prev && cnt_i == 0)     || (m_uif && !f_w1c(1));
      m_irq  <= (m_ccif && m_pcr[2]) || (m_uif && m_pcr[3]);
      if (f_ref(m_pcr, m_ccr, cnt_i) == run_val) run_len <= (run_len < BIG) ? run_len + 1 : run_len;
      else begin
        run_val <= f_ref(m_pcr, m_ccr, cnt_i);
        run_len <= 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      check("pwm_o", {31'd0, pwm_o}, {31'd0, m_live && run_val && run_len > int'(m_dtr)});
      check("irq_o", {31'd0, irq_o}, {31'd0, m_irq});
      check("PREADY", {31'd0, PREADY}, {31'd0, m_pready});
      check("PRDATA", PRDATA, m_prdata);
`ifdef TIMER_PWM_DEADTIME_EN
      check("pwm_n_o", {31'd0, pwm_n_o}, {31'd0, m_live && !run_val && run_len > int'(m_dtr)});
      check("never_both", {31'd0, pwm_o && pwm_n_o}, 32'd0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic setcnt(input logic [31:0] v);
    @(posedge PCLK);
    #1 cnt_i = v;
  endtask

  task automatic apb(input bit w, input logic [3:0] a, input logic [31:0] d, input int cnt_en,
                     output logic [31:0] rd);
    @(posedge PCLK);
    #1; PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK);
    #1; PENABLE = 1;
    if (cnt_en >= 0) cnt_i = cnt_en;
    @(posedge PCLK);
    #1; PSEL = 0; PENABLE = 0; PWRITE = 0;
    rd = PRDATA;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    apb(1'b1, a, d, -1, unused_rd);
  endtask

  task automatic rdchk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    apb(1'b0, a, 32'd0, -1, r);
    check(name, r, exp);
  endtask

  // Drives cnt_i through 0..9 twice; counts output highs over the second period.
  task automatic run_counts(output int hi, output int hin);
    hi = 0;
    hin = 0;
    for (int k = 0; k <= 20; k++) begin
      @(posedge PCLK);
      #1;
      if (k >= 11) begin
        hi += int'(pwm_o);
`ifdef TIMER_PWM_DEADTIME_EN
        hin += int'(pwm_n_o);
`endif
      end
      cnt_i = k % 10;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, hin;
    logic [31:0] r;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1;
    chk_en = 1;
    for (int a = 0; a < 4; a++) rdchk("reset_read", 4'(a * 4), 32'd0);

    // Reset dropped during the access phase of a CCR write
    wr(4'h0, 32'h9);
    wr(4'h4, 32'd9);
    @(posedge PCLK);
    #1; PSEL = 1; PWRITE = 1; PADDR = 4'h4; PWDATA = 32'd5;
    @(posedge PCLK);
    #1; PENABLE = 1;
    #2 PRESET = 0;
    @(posedge PCLK);
    #1; PSEL = 0; PENABLE = 0; PWRITE = 0;
    check("rst_pwm", {31'd0, pwm_o}, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);
    tick(2);
    PRESET = 1;
    for (int a = 0; a < 4; a++) rdchk("abort_read", 4'(a * 4), 32'd0);

    // Duty cycle, polarity and boundaries
    wr(4'h4, 32'd3); wr(4'h0, 32'h1);
    run_counts(hi, hin); check("duty_ccr3", hi, 3);
    wr(4'h0, 32'h3);
    run_counts(hi, hin); check("duty_ccr3_pol", hi, 7);
    wr(4'h4, 32'd0); wr(4'h0, 32'h1);
    run_counts(hi, hin); check("duty_ccr0", hi, 0);
    wr(4'h4, 32'hFFFF_FFFF);
    run_counts(hi, hin); check("duty_ccrmax", hi, 10);
    wr(4'h0, 32'h2);
    run_counts(hi, hin); check("disabled_pol", hi, 10);
    rdchk("pcr_read", 4'h0, 32'h2);
    rdchk("ccr_read", 4'h4, 32'hFFFF_FFFF);

    // Compare flag, W1C and set-wins-over-clear
    wr(4'h8, 32'h3);
    wr(4'h4, 32'd4); wr(4'h0, 32'h5);
    setcnt(3); setcnt(4);
    tick(1); check("irq_not_yet", {31'd0, irq_o}, 32'd0);
    tick(1); check("irq_cc", {31'd0, irq_o}, 32'd1);
    rdchk("sr_ccif", 4'h8, 32'd1);
    wr(4'h8, 32'h1);
    tick(1); check("irq_cleared", {31'd0, irq_o}, 32'd0);
    setcnt(3);
    apb(1'b1, 4'h8, 32'h1, 4, r);
    rdchk("set_wins", 4'h8, 32'd1);
    wr(4'h8, 32'h1);
    rdchk("sr_clear", 4'h8, 32'd0);

    // Update flag on wrap, no re-set while the count sits at zero
    wr(4'h0, 32'h9);
    setcnt(9); setcnt(0);
    tick(2); check("irq_uf", {31'd0, irq_o}, 32'd1);
    rdchk("sr_uif", 4'h8, 32'd2);
    wr(4'h8, 32'h2);
    tick(5);
    rdchk("sr_hold0", 4'h8, 32'd0);
    check("irq_hold0", {31'd0, irq_o}, 32'd0);

    // Dead-time register and complementary outputs
    wr(4'hC, 32'h1_0002);
`ifdef TIMER_PWM_DEADTIME_EN
    rdchk("dtr_read", 4'hC, 32'd2);
    wr(4'h4, 32'd5); wr(4'h0, 32'h1);
    run_counts(hi, hin);
    check("dt_pwm_high", hi, 3);
    check("dt_pwm_n_high", hin, 3);
    wr(4'h0, 32'h0);
    wr(4'hC, 32'h0);
`else
    rdchk("dtr_read", 4'hC, 32'd0);
`endif

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      int sel;
      int a;
      logic [31:0] d;
      sel = $urandom_range(0, 9);
      a = $urandom_range(0, 2);
      if (sel < 5) begin
        setcnt((sel == 0) ? cnt_i : 32'($urandom_range(0, 12)));
      end else if (sel < 8) begin
        d = $urandom;
        if (a == 1) d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
        apb(1'b1, 4'(a * 4), d, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : -1, r);
      end else begin
        apb(1'b0, 4'($urandom_range(0, 3) * 4), 32'd0, -1, r);
      end
    end

    tick(2);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_pwm.md
TIMER_PWM -- requirements
Module: timer_pwm

Interface
REQ-001 SHALL have parameter DT_W, default 8, dead-time counter width in bits.
REQ-002 SHALL have port PCLK  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port PRESET  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports PADDR in 4, PWDATA in 32, PWRITE in 1, PENABLE in 1, PSEL in 1: APB slave request.
REQ-005 SHALL have ports PRDATA out 32, PREADY out 1: APB slave response.
REQ-006 SHALL have port cnt_i  input  32  live counter value from the upstream timer.
REQ-007 SHALL have port pwm_o  output  1  PWM output.
REQ-008 SHALL have port pwm_n_o  output  1  complementary PWM output, present only with TIMER_PWM_DEADTIME_EN.
REQ-009 SHALL have port irq_o  output  1  level interrupt request.

Function
REQ-010 SHALL decode PADDR[3:2]: 0 PCR, 1 CCR, 2 SR, 3 DTR.
REQ-011 PCR: bit0 EN, bit1 POL, bit2 CCIE, bit3 UIE; other bits read 0.
REQ-012 CCR: 32-bit compare value, read/write.
REQ-013 SR: bit0 CCIF, bit1 UIF; writing 1 clears the bit, writing 0 has no effect; other bits read 0.
REQ-014 APB: on PSEL&&PENABLE, perform the access and assert PREADY for the following cycle; PREADY low otherwise; a write takes effect on the same edge.
REQ-015 Reads: PRDATA registered on the access edge; it holds its value when not accessed.
REQ-016 Raw compare: raw = (cnt_i < CCR), unsigned 32-bit; CCR=0 gives 0 % duty; CCR > counter maximum gives 100 %.
REQ-017 pwm_o SHALL be registered: EN=1 gives raw^POL, EN=0 gives POL; latency 1 cycle from cnt_i.
REQ-018 A registered copy cnt_d of cnt_i SHALL be kept; a change is detected when cnt_i != cnt_d.
REQ-019 CCIF SHALL set on the cycle after a change in which cnt_i == CCR.
REQ-020 UIF SHALL set on the cycle after a change in which cnt_i == 0 (wrap or clear).
REQ-021 If a flag set and a W1C of that flag occur in the same cycle, the set SHALL win.
REQ-022 irq_o SHALL be registered: (CCIF&CCIE)|(UIF&UIE), 1-cycle latency.
REQ-023 Flags SHALL be updated regardless of EN.

Reset
REQ-024 While PRESET is low: all registers, cnt_d, PRDATA = 0; PREADY = 0; pwm_o = 0; irq_o = 0; pwm_n_o = 0; dead-time counter = 0.
REQ-025 Reset asserted mid-access SHALL abort the access with no register update.

Configuration
REQ-026 Macro TIMER_PWM_DEADTIME_EN defined: DTR[DT_W-1:0] is read/write; pwm_o and pwm_n_o are complementary, each rising edge delayed by DTR cycles with both outputs low during the delay; DTR=0 means no delay; any opposite transition during the delay restarts it.
REQ-027 Macro TIMER_PWM_DEADTIME_EN undefined: no pwm_n_o port; DTR reads 0 and writes are ignored; pwm_o behaves per REQ-017.

Structure
REQ-028 Package timer_pwm_pkg SHALL hold the register offset constants, PCR/SR bit-index constants and the register-index enum.
REQ-029 Dead-time generation SHALL be the sub-module timer_pwm_deadtime, instantiated only under the macro.

Verification
REQ-030 Reset: PRESET low mid-write of CCR=5 -> all reads return 0, pwm_o=0, irq_o=0.
REQ-031 PWM: CCR=3, PCR=1, cnt_i cycling 0..9 -> pwm_o high for 3 of 10 counts, 1 cycle after cnt_i; POL=1 -> inverted.
REQ-032 Boundaries: CCR=0 -> pwm_o constant 0; CCR=0xFFFFFFFF, cnt_i cycling 0..9 -> constant 1; EN=0, POL=1 -> constant 1.
REQ-033 Flags: CCR=4, PCR=0x5, cnt_i steps 3->4 -> SR=1, irq_o high next cycle; write SR=1 -> irq_o low; set and clear in the same cycle -> CCIF stays 1.
REQ-034 Wrap: UIE=1, cnt_i 9->0 -> UIF=1, irq_o=1; cnt_i held at 0 for several cycles -> no re-set after clear.
REQ-035 With macro: DTR=2, CCR=5 -> pwm_o rises 2 cycles after raw rises and pwm_n_o rises 2 cycles after raw falls; never both high.
